// File: rtl/event_injector_pkg.sv
// Shared types and constants for the event_injector AXI-Stream trigger source.
package event_injector_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int CNT_WIDTH = 64;

    // Wide enough for any supported TDATA width; sliced to TKEEP_WIDTH by the user.
    localparam logic [1023:0] TKEEP_ONES = '1;

endpackage

// File: rtl/event_injector_pattern.sv
// Beat-position tracker: in-packet index and trigger-period phase of the next beat to load.
module event_injector_pattern #(
    parameter int CFG_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 aresetn,
    input  logic                 i_init,
    input  logic                 i_load,
    input  logic [CFG_WIDTH-1:0] i_pkt_beats,
    input  logic [CFG_WIDTH-1:0] i_period,
    output logic                 o_trig,
    output logic                 o_last
);

    logic [CFG_WIDTH-1:0] r_idx;
    logic [CFG_WIDTH-1:0] r_phase;
    logic [CFG_WIDTH-1:0] w_idx;
    logic [CFG_WIDTH-1:0] w_phase;

    // i_init describes beat 1 directly; the registers then describe the following beat.
    assign w_idx   = i_init ? '0 : r_idx;
    assign w_phase = i_init ? '0 : r_phase;
    assign o_last  = (w_idx == i_pkt_beats - CFG_WIDTH'(1));
    assign o_trig  = (i_period != '0) && (w_phase == i_period - CFG_WIDTH'(1));

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_idx   <= '0;
            r_phase <= '0;
        end else if (i_init || i_load) begin
            r_idx   <= o_last ? '0 : w_idx + CFG_WIDTH'(1);
            r_phase <= ((i_period == '0) || o_trig) ? '0 : w_phase + CFG_WIDTH'(1);
        end
    end

endmodule

// File: rtl/event_injector.sv
// AXI-Stream filler/trigger source with exact beat and trigger counters.
// Optional macro EVENT_INJECTOR_SEQ_EN: filler beats carry the running beat count in TDATA[31:0].
module event_injector
    import event_injector_pkg::*;
#(
    parameter int TDATA_WIDTH = 512,
    parameter int TKEEP_WIDTH = TDATA_WIDTH / 8,
    parameter int TDEST_WIDTH = 16,
    parameter int TID_WIDTH   = 16,
    parameter int CFG_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   aresetn,
    input  logic                   start,
    input  logic [CFG_WIDTH-1:0]   pkt_beats,
    input  logic [CFG_WIDTH-1:0]   trigger_period,
    input  logic [CFG_WIDTH-1:0]   num_pkts,
    input  logic [TDATA_WIDTH-1:0] trigger_value,
    input  logic [TDATA_WIDTH-1:0] filler_value,
    input  logic [TDEST_WIDTH-1:0] cfg_tdest,
    input  logic [TID_WIDTH-1:0]   cfg_tid,
    output logic [TDATA_WIDTH-1:0] out_stream_TDATA,
    output logic [TKEEP_WIDTH-1:0] out_stream_TKEEP,
    output logic [TDEST_WIDTH-1:0] out_stream_TDEST,
    output logic [TID_WIDTH-1:0]   out_stream_TID,
    output logic                   out_stream_TVALID,
    input  logic                   out_stream_TREADY,
    output logic                   out_stream_TLAST,
    output logic [CNT_WIDTH-1:0]   trig_sent,
    output logic [CNT_WIDTH-1:0]   beats_sent,
    output logic                   busy,
    output logic                   done
);

    state_t                 r_state;
    logic                   r_start_d;
    logic [CFG_WIDTH-1:0]   r_pkt_beats;
    logic [CFG_WIDTH-1:0]   r_period;
    logic [CFG_WIDTH-1:0]   r_num_pkts;
    logic [CFG_WIDTH-1:0]   r_pkt_cnt;
    logic [TDATA_WIDTH-1:0] r_trig_val;
    logic [TDATA_WIDTH-1:0] r_fill_val;
    logic [TDATA_WIDTH-1:0] r_tdata;
    logic [TKEEP_WIDTH-1:0] r_tkeep;
    logic [TDEST_WIDTH-1:0] r_tdest;
    logic [TID_WIDTH-1:0]   r_tid;
    logic                   r_tvalid;
    logic                   r_tlast;
    logic                   r_cur_trig;
    logic [CNT_WIDTH-1:0]   r_trig_sent;
    logic [CNT_WIDTH-1:0]   r_beats_sent;
    logic                   r_busy;
    logic                   r_done;

    logic                   w_init;
    logic                   w_hs;
    logic                   w_last_pkt;
    logic                   w_finish;
    logic                   w_load;
    logic [CFG_WIDTH-1:0]   w_pb_live;
    logic [CFG_WIDTH-1:0]   w_cfg_pb;
    logic [CFG_WIDTH-1:0]   w_cfg_per;
    logic [TDATA_WIDTH-1:0] w_trig_src;
    logic [TDATA_WIDTH-1:0] w_fill_src;
    logic [TDATA_WIDTH-1:0] w_fill_data;
    logic [TDATA_WIDTH-1:0] w_next_data;
    logic                   w_next_trig;
    logic                   w_next_last;

    assign w_init     = (r_state == IDLE) && start && !r_start_d;
    assign w_hs       = r_tvalid && out_stream_TREADY;
    assign w_last_pkt = (r_num_pkts != '0) && (r_pkt_cnt == r_num_pkts - CFG_WIDTH'(1));
    assign w_finish   = w_hs && r_tlast &&
                        (((r_state == RUN) && (w_last_pkt || !start)) || (r_state == DRAIN));
    assign w_load     = w_init || (w_hs && !w_finish);

    // The first beat is built in the start-edge cycle, before the latched config exists.
    assign w_pb_live  = (pkt_beats == '0) ? CFG_WIDTH'(1) : pkt_beats;
    assign w_cfg_pb   = w_init ? w_pb_live : r_pkt_beats;
    assign w_cfg_per  = w_init ? trigger_period : r_period;
    assign w_trig_src = w_init ? trigger_value : r_trig_val;
    assign w_fill_src = w_init ? filler_value : r_fill_val;

`ifdef EVENT_INJECTOR_SEQ_EN
    logic [CNT_WIDTH-1:0] w_seq;
    // Value beats_sent will hold when the beat being loaded is accepted.
    assign w_seq       = w_init ? '0 : r_beats_sent + CNT_WIDTH'(1);
    assign w_fill_data = {w_fill_src[TDATA_WIDTH-1:32], w_seq[31:0]};
`else
    assign w_fill_data = w_fill_src;
`endif

    assign w_next_data = w_next_trig ? w_trig_src : w_fill_data;

    event_injector_pattern #(
        .CFG_WIDTH (CFG_WIDTH)
    ) u_pattern (
        .clk         (clk),
        .aresetn     (aresetn),
        .i_init      (w_init),
        .i_load      (w_load),
        .i_pkt_beats (w_cfg_pb),
        .i_period    (w_cfg_per),
        .o_trig      (w_next_trig),
        .o_last      (w_next_last)
    );

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_state      <= IDLE;
            r_start_d    <= 1'b1;   // a start held through reset must not count as an edge
            r_pkt_beats  <= '0;
            r_period     <= '0;
            r_num_pkts   <= '0;
            r_pkt_cnt    <= '0;
            r_trig_val   <= '0;
            r_fill_val   <= '0;
            r_tdata      <= '0;
            r_tkeep      <= '0;
            r_tdest      <= '0;
            r_tid        <= '0;
            r_tvalid     <= 1'b0;
            r_tlast      <= 1'b0;
            r_cur_trig   <= 1'b0;
            r_trig_sent  <= '0;
            r_beats_sent <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_start_d <= start;
            r_done    <= 1'b0;
            if (w_load) begin
                r_tdata    <= w_next_data;
                r_tlast    <= w_next_last;
                r_cur_trig <= w_next_trig;
                r_tkeep    <= TKEEP_ONES[TKEEP_WIDTH-1:0];
            end
            if (w_hs) begin
                r_beats_sent <= r_beats_sent + CNT_WIDTH'(1);
                r_trig_sent  <= r_trig_sent + CNT_WIDTH'(r_cur_trig);
            end
            case (r_state)
                IDLE: begin
                    if (w_init) begin
                        r_pkt_beats  <= w_pb_live;
                        r_period     <= trigger_period;
                        r_num_pkts   <= num_pkts;
                        r_trig_val   <= trigger_value;
                        r_fill_val   <= filler_value;
                        r_tdest      <= cfg_tdest;
                        r_tid        <= cfg_tid;
                        r_pkt_cnt    <= '0;
                        r_trig_sent  <= '0;
                        r_beats_sent <= '0;
                        r_tvalid     <= 1'b1;
                        r_busy       <= 1'b1;
                        r_state      <= RUN;
                    end
                end
                RUN: begin
                    if (w_finish) begin
                        r_tvalid <= 1'b0;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= DONE;
                    end else begin
                        if (w_hs && r_tlast) begin
                            r_pkt_cnt <= r_pkt_cnt + CFG_WIDTH'(1);
                        end
                        if (!start) begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (w_finish) begin
                        r_tvalid <= 1'b0;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= DONE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign out_stream_TDATA  = r_tdata;
    assign out_stream_TKEEP  = r_tkeep;
    assign out_stream_TDEST  = r_tdest;
    assign out_stream_TID    = r_tid;
    assign out_stream_TVALID = r_tvalid;
    assign out_stream_TLAST  = r_tlast;
    assign trig_sent         = r_trig_sent;
    assign beats_sent        = r_beats_sent;
    assign busy              = r_busy;
    assign done              = r_done;

endmodule

// File: tb/tb_event_injector.sv
// Randomized self-checking bench for event_injector against a beat-position reference model.
// Honors EVENT_INJECTOR_SEQ_EN for the expected filler data.
module tb_event_injector;

    localparam int DW    = 64;
    localparam int KW    = DW / 8;
    localparam int DESTW = 16;
    localparam int IDW   = 16;
    localparam int CW    = 16;

    logic            clk = 1'b0;
    logic            aresetn;
    logic            start;
    logic [CW-1:0]   pkt_beats, trigger_period, num_pkts;
    logic [DW-1:0]   trigger_value, filler_value;
    logic [DESTW-1:0] cfg_tdest;
    logic [IDW-1:0]  cfg_tid;
    logic [DW-1:0]   tdata;
    logic [KW-1:0]   tkeep;
    logic [DESTW-1:0] tdest;
    logic [IDW-1:0]  tid;
    logic            tvalid, tready, tlast;
    logic [63:0]     trig_sent, beats_sent;
    logic            busy, done;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    event_injector #(
        .TDATA_WIDTH (DW),
        .TKEEP_WIDTH (KW),
        .TDEST_WIDTH (DESTW),
        .TID_WIDTH   (IDW),
        .CFG_WIDTH   (CW)
    ) dut (
        .clk               (clk),
        .aresetn           (aresetn),
        .start             (start),
        .pkt_beats         (pkt_beats),
        .trigger_period    (trigger_period),
        .num_pkts          (num_pkts),
        .trigger_value     (trigger_value),
        .filler_value      (filler_value),
        .cfg_tdest         (cfg_tdest),
        .cfg_tid           (cfg_tid),
        .out_stream_TDATA  (tdata),
        .out_stream_TKEEP  (tkeep),
        .out_stream_TDEST  (tdest),
        .out_stream_TID    (tid),
        .out_stream_TVALID (tvalid),
        .out_stream_TREADY (tready),
        .out_stream_TLAST  (tlast),
        .trig_sent         (trig_sent),
        .beats_sent        (beats_sent),
        .busy              (busy),
        .done              (done)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected TDATA of beat k (1-based) in a run.
    function automatic logic [DW-1:0] model_data(input int k, input int per,
                                                 input logic [DW-1:0] tv, input logic [DW-1:0] fv);
        logic [31:0] seq;
        if (per != 0 && (k % per) == 0) return tv;
        seq = 32'(k - 1);
`ifdef EVENT_INJECTOR_SEQ_EN
        return {fv[DW-1:32], seq};
`else
        if (seq == 32'hFFFF_FFFF) return ~fv;
        return fv;
`endif
    endfunction

    // stop_at: start drops together with acceptance of that beat (0 = keep start high).
    task automatic run_case(input int pb, input int per, input int np, input int rdy_pct,
                            input int stop_at, input logic [DW-1:0] tv, input logic [DW-1:0] fv);
        logic [DW-1:0] exp_data[$];
        logic          exp_last[$];
        int            eff_pb, total, exp_trig, got, dones, cyc;
        logic          finished, prev_stall, prev_last;
        logic [DW-1:0] prev_data;
        logic [DESTW-1:0] dst;
        logic [IDW-1:0]   idv;

        eff_pb   = (pb == 0) ? 1 : pb;
        total    = (np != 0) ? np * eff_pb : ((stop_at + eff_pb - 1) / eff_pb) * eff_pb;
        exp_trig = 0;
        for (int k = 1; k <= total; k++) begin
            exp_data.push_back(model_data(k, per, tv, fv));
            exp_last.push_back((k % eff_pb) == 0);
            if (per != 0 && (k % per) == 0) exp_trig++;
        end
        dst = DESTW'($urandom);
        idv = IDW'($urandom);

        @(negedge clk);
        pkt_beats      = CW'(pb);
        trigger_period = CW'(per);
        num_pkts       = CW'(np);
        trigger_value  = tv;
        filler_value   = fv;
        cfg_tdest      = dst;
        cfg_tid        = idv;
        start          = 1'b1;

        got = 0; dones = 0; cyc = 0;
        finished = 1'b0; prev_stall = 1'b0; prev_last = 1'b0; prev_data = '0;
        while (!finished && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            // Live config edits must not reach a run in progress.
            pkt_beats      = CW'($urandom);
            trigger_period = CW'($urandom);
            trigger_value  = DW'({$urandom, $urandom});
            cfg_tdest      = DESTW'($urandom);
            if (cyc == 1) begin
                check_val("first_valid", 64'(tvalid), 64'd1);
                check_val("busy_run", 64'(busy), 64'd1);
            end
            if (prev_stall) begin
                check_val("hold_valid", 64'(tvalid), 64'd1);
                check_val("hold_data", tdata, prev_data);
                check_val("hold_last", 64'(tlast), 64'(prev_last));
            end
            if (done) begin
                dones++;
                finished = 1'b1;
            end
            tready = ($urandom_range(99) < rdy_pct);
            if (tvalid && tready) begin
                if (got < total) begin
                    check_val("beat_data", tdata, exp_data[got]);
                    check_val("beat_last", 64'(tlast), 64'(exp_last[got]));
                    check_val("beat_side", {tkeep, tdest, tid}, {KW'('1), dst, idv});
                end else begin
                    check_val("extra_beat", 64'(got + 1), 64'(total));
                end
                got++;
                if (stop_at != 0 && got == stop_at) start = 1'b0;
            end
            prev_stall = tvalid && !tready;
            prev_data  = tdata;
            prev_last  = tlast;
        end
        if (!finished) check_val("done_timeout", 64'd0, 64'd1);
        check_val("beat_count", 64'(got), 64'(total));
        check_val("beats_sent", beats_sent, 64'(total));
        check_val("trig_sent", trig_sent, 64'(exp_trig));
        check_val("busy_done", 64'(busy), 64'd0);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check_val("done_pulses", 64'(dones), 64'd1);
        check_val("counters_hold", beats_sent, 64'(total));
        $display("[TB] run pb=%0d per=%0d np=%0d rdy=%0d stop=%0d beats=%0d trig=%0d",
                 pb, per, np, rdy_pct, stop_at, got, exp_trig);
    endtask

    initial begin
        logic [DW-1:0] v;
        aresetn = 1'b0; start = 1'b0; tready = 1'b0;
        pkt_beats = '0; trigger_period = '0; num_pkts = '0;
        trigger_value = '0; filler_value = '0; cfg_tdest = '0; cfg_tid = '0;
        repeat (3) @(negedge clk);
        check_val("rst_valid", 64'(tvalid), 64'd0);
        check_val("rst_data", tdata, 64'd0);
        check_val("rst_cnt", beats_sent | trig_sent, 64'd0);
        check_val("rst_flags", {61'd0, busy, done, tlast}, 64'd0);
        aresetn = 1'b1;
        @(negedge clk);

        run_case(4, 3, 3, 100, 0, 64'hCAFE_0000_0000_1111, 64'hF111_2222_3333_4444);
        run_case(4, 3, 3, 50, 0, 64'hCAFE_0000_0000_1111, 64'hF111_2222_3333_4444);
        run_case(5, 0, 0, 100, 7, 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555);
        run_case(0, 0, 2, 100, 0, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321);
        run_case(3, 2, 2, 70, 0, 64'hDEAD_BEEF_DEAD_BEEF, 64'h7777_0000_0000_0000);
        v = {$urandom, $urandom};
        run_case(3, 1, 2, 60, 0, v, v);
        for (int r = 0; r < 6; r++) begin
            run_case($urandom_range(6), $urandom_range(5), $urandom_range(1, 4),
                     $urandom_range(30, 100), 0, {$urandom, $urandom}, {$urandom, $urandom});
        end
        for (int r = 0; r < 3; r++) begin
            run_case($urandom_range(1, 5), $urandom_range(4), 0, $urandom_range(40, 100),
                     $urandom_range(1, 12), {$urandom, $urandom}, {$urandom, $urandom});
        end

        // Reset mid-packet while stalled, with start held high afterwards.
        @(negedge clk);
        pkt_beats = 16'd4; trigger_period = 16'd2; num_pkts = 16'd0;
        tready = 1'b0; start = 1'b1;
        repeat (3) @(negedge clk);
        check_val("pre_rst_valid", 64'(tvalid), 64'd1);
        #2 aresetn = 1'b0;
        #1;
        check_val("async_rst_valid", 64'(tvalid), 64'd0);
        check_val("async_rst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        aresetn = 1'b1;
        tready  = 1'b1;
        repeat (5) @(negedge clk);
        check_val("no_edge_valid", 64'(tvalid), 64'd0);
        check_val("no_edge_busy", 64'(busy), 64'd0);
        check_val("no_edge_cnt", beats_sent, 64'd0);
        start = 1'b0;
        @(negedge clk);
        run_case(2, 2, 2, 100, 0, 64'h0101_0101_0101_0101, 64'h0202_0202_0202_0202);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
